// File: rtl/decode_stage_nw.sv
// N-wide registered decode stage: per-lane RV32I decode, packed immediates and a
// cross-bundle short-forward-branch shadow tracker, behind a one-deep valid/ready register.

// Per-lane ctrl layout (16 bits):
// [15] legal [14:10] uop [9:8] iq [7:6] exu [5] rd_wen [4] rs1_ren [3] rs2_ren [2:0] imm_sel
module decode_lane_nw (
    input  logic [31:0] instr_i,
    output logic [15:0] ctrl_o,
    output logic [31:0] imm_o,
    output logic [19:0] pimm_o,
    output logic        shadowable_o,
    output logic        is_br_o
);
    localparam logic [4:0] UOP_NOP = 5'd0, UOP_LUI = 5'd1, UOP_AUIPC = 5'd2, UOP_JAL = 5'd3,
                           UOP_JALR = 5'd4, UOP_BR = 5'd5, UOP_LD = 5'd6, UOP_ST = 5'd7,
                           UOP_ALUI = 5'd8, UOP_ALU = 5'd9, UOP_FENCE = 5'd10, UOP_SYS = 5'd11;
    localparam logic [1:0] IQ_INT = 2'd0, IQ_MEM = 2'd1, IQ_SYS = 2'd2;
    localparam logic [1:0] EXU_ALU = 2'd0, EXU_BR = 2'd1, EXU_LSU = 2'd2, EXU_SYS = 2'd3;
    localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3,
                           IMM_U = 3'd4, IMM_J = 3'd5;

    logic [6:0] opc, f7;
    logic [2:0] f3, isel;
    logic [4:0] uop, mid5;
    logic [1:0] iq, exu;
    logic       legal, rd_w, rs1_r, rs2_r, alu, br;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    always_comb begin
        legal = 1'b0; uop = UOP_NOP; iq = IQ_INT; exu = EXU_ALU;
        rd_w = 1'b0; rs1_r = 1'b0; rs2_r = 1'b0; isel = IMM_NONE; alu = 1'b0; br = 1'b0;
        case (opc)
            7'h37, 7'h17: begin
                legal = 1'b1; uop = (opc == 7'h37) ? UOP_LUI : UOP_AUIPC;
                rd_w = 1'b1; isel = IMM_U; alu = 1'b1;
            end
            7'h6F: begin
                legal = 1'b1; uop = UOP_JAL; exu = EXU_BR; rd_w = 1'b1; isel = IMM_J;
            end
            7'h67: if (f3 == 3'b000) begin
                legal = 1'b1; uop = UOP_JALR; exu = EXU_BR; rd_w = 1'b1; rs1_r = 1'b1; isel = IMM_I;
            end
            7'h63: if (f3 != 3'b010 && f3 != 3'b011) begin
                legal = 1'b1; uop = UOP_BR; exu = EXU_BR; rs1_r = 1'b1; rs2_r = 1'b1;
                isel = IMM_B; br = 1'b1;
            end
            7'h03: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                legal = 1'b1; uop = UOP_LD; iq = IQ_MEM; exu = EXU_LSU;
                rd_w = 1'b1; rs1_r = 1'b1; isel = IMM_I;
            end
            7'h23: if (f3 <= 3'b010) begin
                legal = 1'b1; uop = UOP_ST; iq = IQ_MEM; exu = EXU_LSU;
                rs1_r = 1'b1; rs2_r = 1'b1; isel = IMM_S;
            end
            7'h13: begin
                // Shift-immediates carry a funct7 that must be canonical.
                legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                        (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                uop = UOP_ALUI; rd_w = 1'b1; rs1_r = 1'b1; isel = IMM_I; alu = 1'b1;
            end
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                uop = UOP_ALU; rd_w = 1'b1; rs1_r = 1'b1; rs2_r = 1'b1; alu = 1'b1;
            end
            7'h0F: if (f3 == 3'b000) begin
                legal = 1'b1; uop = UOP_FENCE; iq = IQ_SYS; exu = EXU_SYS;
            end
            7'h73: if (instr_i == 32'h0000_0073 || instr_i == 32'h0010_0073) begin
                legal = 1'b1; uop = UOP_SYS; iq = IQ_SYS; exu = EXU_SYS;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (isel)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

    assign mid5         = (isel == IMM_S || isel == IMM_B) ? instr_i[11:7] : instr_i[24:20];
    assign pimm_o       = {imm_o[31:25], mid5, imm_o[19:12]};
    assign ctrl_o       = {legal, uop, iq, exu, rd_w, rs1_r, rs2_r, isel};
    assign shadowable_o = legal & alu;
    assign is_br_o      = br;
endmodule

module decode_stage_nw #(
    parameter int WIDTH             = 2,
    parameter int SHADOW_MAX_INSTRS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_pc,
    input  logic [WIDTH*32-1:0]   in_instr,
    input  logic [WIDTH-1:0]      in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [WIDTH-1:0]      out_mask,
    output logic [WIDTH*16-1:0]   out_ctrl,
    output logic [WIDTH*20-1:0]   out_packed_imm,
    output logic [WIDTH-1:0]      out_illegal,
    output logic [WIDTH-1:0]      out_shadowed,
    output logic                  out_sfo_cancel,
    output logic                  shadow_active
);
    localparam logic [31:0] SHADOW_SPAN = 32'(4 * SHADOW_MAX_INSTRS);

    logic [WIDTH-1:0][15:0] lane_ctrl, ctrl_d, ctrl_q;
    logic [WIDTH-1:0][31:0] lane_imm, lane_pc;
    logic [WIDTH-1:0][19:0] lane_pimm, pimm_d, pimm_q;
    logic [WIDTH-1:0]       lane_shad, lane_br, lane_elig;
    logic [WIDTH-1:0]       illegal_d, illegal_q, shadowed_d, shadowed_q, mask_q;
    logic [31:0]            pc_q, sh_end_d, sh_end_q;
    logic                   out_valid_q, cancel_d, cancel_q, sh_active_d, sh_active_q;
    logic                   accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        decode_lane_nw u_lane (
            .instr_i      (in_instr[32*g +: 32]),
            .ctrl_o       (lane_ctrl[g]),
            .imm_o        (lane_imm[g]),
            .pimm_o       (lane_pimm[g]),
            .shadowable_o (lane_shad[g]),
            .is_br_o      (lane_br[g])
        );
        assign lane_pc[g]   = in_pc + 32'(4 * g);
        assign lane_elig[g] = !lane_imm[g][31] && (lane_imm[g] != '0) && (lane_imm[g] <= SHADOW_SPAN);
        assign ctrl_d[g]    = in_mask[g] ? lane_ctrl[g] : '0;
        assign pimm_d[g]    = in_mask[g] ? lane_pimm[g] : '0;
        assign illegal_d[g] = in_mask[g] & ~lane_ctrl[g][15];
    end

    // Walk lanes in program order carrying the running shadow state.
    always_comb begin
        sh_active_d = sh_active_q;
        sh_end_d    = sh_end_q;
        cancel_d    = 1'b0;
        shadowed_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_mask[i]) begin
                if (sh_active_d && lane_pc[i] >= sh_end_d) sh_active_d = 1'b0;
                if (sh_active_d) begin
                    if (lane_shad[i]) begin
                        shadowed_d[i] = 1'b1;
                    end else begin
                        cancel_d    = 1'b1;
                        sh_active_d = 1'b0;
                    end
                end
                if (!sh_active_d && lane_br[i] && lane_elig[i]) begin
                    sh_active_d = 1'b1;
                    sh_end_d    = lane_pc[i] + lane_imm[i];
                end
            end
        end
        if (cancel_d) shadowed_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            mask_q      <= '0;
            ctrl_q      <= '0;
            pimm_q      <= '0;
            illegal_q   <= '0;
            shadowed_q  <= '0;
            cancel_q    <= 1'b0;
            sh_active_q <= 1'b0;
            sh_end_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            sh_active_q <= 1'b0;
            sh_end_q    <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            pc_q        <= in_pc;
            mask_q      <= in_mask;
            ctrl_q      <= ctrl_d;
            pimm_q      <= pimm_d;
            illegal_q   <= illegal_d;
            shadowed_q  <= shadowed_d;
            cancel_q    <= cancel_d;
            sh_active_q <= sh_active_d;
            sh_end_q    <= sh_end_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = pc_q;
    assign out_mask       = mask_q;
    assign out_ctrl       = ctrl_q;
    assign out_packed_imm = pimm_q;
    assign out_illegal    = illegal_q;
    assign out_shadowed   = shadowed_q;
    assign out_sfo_cancel = cancel_q;
    assign shadow_active  = sh_active_q;
endmodule

// File: tb/tb_decode_stage_nw.sv
// Randomized bench for decode_stage_nw: instructions are built from chosen fields and
// immediates, and a bundle-level shadow/pipeline model predicts every output.
module tb_decode_stage_nw;
    localparam int W = 2;
    localparam int SMI = 4;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready, out_sfo_cancel, shadow_active;
    logic [31:0] in_pc, out_pc;
    logic [W*32-1:0] in_instr;
    logic [W-1:0] in_mask, out_mask, out_illegal, out_shadowed;
    logic [W*16-1:0] out_ctrl;
    logic [W*20-1:0] out_packed_imm;

    always #5 clk = ~clk;

    decode_stage_nw #(.WIDTH(W), .SHADOW_MAX_INSTRS(SMI)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_mask(in_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_mask(out_mask), .out_ctrl(out_ctrl),
        .out_packed_imm(out_packed_imm), .out_illegal(out_illegal), .out_shadowed(out_shadowed),
        .out_sfo_cancel(out_sfo_cancel), .shadow_active(shadow_active)
    );

    typedef struct {
        logic [31:0] instr;
        bit          legal;
        bit          shad;
        bit          br;
        int          off;
        logic [2:0]  isel;
        logic [31:0] imm;
    } ins_t;

    int checks = 0;
    int fails = 0;

    // reference model state
    bit          mv, mact, mcancel;
    logic [31:0] mend, mpc;
    logic [W-1:0] mmask, mill, mshad, mleg;
    logic [W-1:0][2:0]  misel;
    logic [W-1:0][19:0] mpimm;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t mk_i(logic [6:0] op, logic [2:0] f3, logic [11:0] imm, bit shad);
        ins_t r;
        r.instr = {imm, 5'($urandom), f3, 5'($urandom), op};
        r.legal = 1; r.shad = shad; r.br = 0; r.off = 0; r.isel = 3'd1;
        r.imm = {{20{imm[11]}}, imm};
        return r;
    endfunction

    function automatic ins_t mk_addi();
        ins_t r;
        r = mk_i(7'h13, 3'd0, 12'd1, 1);
        r.instr = 32'h0010_8093;
        return r;
    endfunction

    function automatic ins_t mk_b(int off, logic [2:0] f3);
        ins_t r;
        logic [12:0] o;
        o = 13'(off);
        r.instr = {o[12], o[10:5], 5'd0, 5'd0, f3, o[4:1], o[11], 7'h63};
        r.legal = 1; r.shad = 0; r.br = 1; r.off = off; r.isel = 3'd3; r.imm = 32'(off);
        return r;
    endfunction

    function automatic ins_t mk_s(logic [11:0] imm, logic [2:0] f3);
        ins_t r;
        r.instr = {imm[11:5], 5'($urandom), 5'($urandom), f3, imm[4:0], 7'h23};
        r.legal = 1; r.shad = 0; r.br = 0; r.off = 0; r.isel = 3'd2;
        r.imm = {{20{imm[11]}}, imm};
        return r;
    endfunction

    function automatic ins_t mk_plain(logic [31:0] w, bit legal, bit shad);
        ins_t r;
        r.instr = w; r.legal = legal; r.shad = shad; r.br = 0; r.off = 0;
        r.isel = 3'd0; r.imm = '0;
        return r;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t r;
        int offs [9];
        logic [2:0] f3;
        logic [19:0] u;
        logic [20:0] jo;
        int j;
        offs = '{-8, -4, 0, 4, 8, 12, 16, 20, 32};
        case ($urandom_range(0, 9))
            0, 1: begin
                f3 = 3'($urandom_range(0, 5));
                f3 = (f3 == 3'd0) ? 3'd0 : (f3 == 3'd1) ? 3'd2 : f3 + 3'd1;
                if (f3 == 3'd5) f3 = 3'd6;
                r = mk_i(7'h13, f3, 12'($urandom), 1);
            end
            2: begin
                f3 = 3'($urandom);
                r = mk_plain({((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                              10'($urandom), f3, 5'($urandom), 7'h33}, 1, 1);
            end
            3: begin
                u = 20'($urandom);
                r = mk_plain({u, 5'($urandom), $urandom_range(0, 1) == 1 ? 7'h17 : 7'h37}, 1, 1);
                r.isel = 3'd4; r.imm = {u, 12'b0};
            end
            4, 5: begin
                f3 = 3'($urandom_range(0, 5));
                if (f3 >= 3'd2) f3 = f3 + 3'd2;
                r = mk_b(offs[$urandom_range(0, 8)], f3);
            end
            6: begin
                j = int'($urandom_range(0, 2047)) * 2 - 2048;
                jo = 21'(j);
                r = mk_plain({jo[20], jo[10:1], jo[11], jo[19:12], 5'($urandom), 7'h6F}, 1, 0);
                r.isel = 3'd5; r.imm = 32'(j);
            end
            7: begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd4; else if (f3 == 3'd4) f3 = 3'd5;
                r = mk_i(7'h03, f3, 12'($urandom), 0);
            end
            8: r = mk_s(12'($urandom), 3'($urandom_range(0, 2)));
            default: r = mk_plain($urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : {25'($urandom), 7'h0B}, 0, 0);
        endcase
        return r;
    endfunction

    task automatic model_accept(input logic [31:0] pc, input ins_t a, input ins_t b, input logic [W-1:0] m);
        ins_t ln [W];
        logic [31:0] p;
        logic [4:0] mid;
        ln[0] = a; ln[1] = b;
        mcancel = 0; mshad = '0;
        for (int i = 0; i < W; i++) begin
            mleg[i] = m[i] && ln[i].legal;
            mill[i] = m[i] && !ln[i].legal;
            misel[i] = m[i] ? ln[i].isel : 3'd0;
            mid = (ln[i].isel == 3'd2 || ln[i].isel == 3'd3) ? ln[i].instr[11:7] : ln[i].instr[24:20];
            mpimm[i] = m[i] ? {ln[i].imm[31:25], mid, ln[i].imm[19:12]} : 20'd0;
            if (m[i]) begin
                p = pc + 32'(4 * i);
                if (mact && p >= mend) mact = 0;
                if (mact) begin
                    if (ln[i].legal && ln[i].shad) mshad[i] = 1;
                    else begin mcancel = 1; mact = 0; end
                end
                if (!mact && ln[i].br && ln[i].off > 0 && ln[i].off <= 4 * SMI) begin
                    mact = 1; mend = p + 32'(ln[i].off);
                end
            end
        end
        if (mcancel) mshad = '0;
        mv = 1; mpc = pc; mmask = m;
    endtask

    task automatic check_out();
        chk("out_valid", 64'(out_valid), 64'(mv));
        chk("shadow_active", 64'(shadow_active), 64'(mact));
        if (mv) begin
            chk("out_pc", 64'(out_pc), 64'(mpc));
            chk("out_mask", 64'(out_mask), 64'(mmask));
            chk("out_illegal", 64'(out_illegal), 64'(mill));
            chk("out_shadowed", 64'(out_shadowed), 64'(mshad));
            chk("out_sfo_cancel", 64'(out_sfo_cancel), 64'(mcancel));
            for (int i = 0; i < W; i++) begin
                chk("ctrl.legal", 64'(out_ctrl[16*i+15]), 64'(mleg[i]));
                chk("ctrl.imm_sel", 64'(out_ctrl[16*i +: 3]), 64'(misel[i]));
                chk("packed_imm", 64'(out_packed_imm[20*i +: 20]), 64'(mpimm[i]));
            end
        end
    endtask

    // One cycle: drive at the falling edge, check outputs at the next falling edge.
    task automatic cyc(input bit v, input logic [31:0] pc, input ins_t a, input ins_t b,
                       input logic [W-1:0] m, input bit rdy, input bit fl);
        bit exp_rdy;
        in_valid = v; in_pc = pc; in_instr = {b.instr, a.instr}; in_mask = m;
        out_ready = rdy; flush = fl;
        #1;
        exp_rdy = !mv || rdy;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (fl) begin mv = 0; mact = 0; mend = '0; end
        else if (v && exp_rdy) model_accept(pc, a, b, m);
        else if (mv && rdy) mv = 0;
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        ins_t addi, beq12, beq20, sw, bad, x, y;
        logic [31:0] pc, npc;
        logic [W-1:0] m;
        addi = mk_addi(); beq12 = mk_b(12, 3'd0); beq20 = mk_b(20, 3'd0);
        sw = mk_plain(32'h0000_2023, 1, 0); sw.isel = 3'd2;
        bad = mk_plain(32'hFFFF_FFFF, 0, 0);
        mv = 0; mact = 0; mend = '0; mcancel = 0;

        rst = 1; flush = 0; in_valid = 0; in_pc = '0; in_instr = '0; in_mask = '0; out_ready = 1;
        #3;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst shadow_active", 64'(shadow_active), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_pc", 64'(out_pc), 64'd0);
        chk("rst out_shadowed", 64'(out_shadowed), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // basic bundle
        cyc(1, 32'h100, addi, addi, 2'b11, 1, 0);
        chk("basic valid", 64'(out_valid), 64'd1);
        chk("basic pc", 64'(out_pc), 64'h100);
        chk("basic legal", 64'({out_ctrl[31], out_ctrl[15]}), 64'b11);
        chk("basic shadowed", 64'(out_shadowed), 64'd0);
        chk("basic illegal", 64'(out_illegal), 64'd0);

        // shadow carried into the next bundle and closed at shadow_end
        cyc(1, 32'h100, beq12, addi, 2'b11, 1, 0);
        chk("sh0 shadowed", 64'(out_shadowed), 64'b10);
        chk("sh0 active", 64'(shadow_active), 64'd1);
        cyc(1, 32'h108, addi, addi, 2'b11, 1, 0);
        chk("sh1 shadowed", 64'(out_shadowed), 64'b01);
        chk("sh1 active", 64'(shadow_active), 64'd0);
        cyc(1, 32'h100, beq20, addi, 2'b11, 1, 0);
        chk("far beq shadowed", 64'(out_shadowed), 64'd0);
        chk("far beq active", 64'(shadow_active), 64'd0);

        // cancel by store and by illegal
        cyc(1, 32'h100, beq12, addi, 2'b11, 1, 0);
        cyc(1, 32'h108, sw, addi, 2'b11, 1, 0);
        chk("sw cancel", 64'(out_sfo_cancel), 64'd1);
        chk("sw shadowed", 64'(out_shadowed), 64'd0);
        chk("sw active", 64'(shadow_active), 64'd0);
        cyc(1, 32'h100, beq12, addi, 2'b11, 1, 0);
        cyc(1, 32'h108, bad, addi, 2'b11, 1, 0);
        chk("ill illegal", 64'(out_illegal), 64'b01);
        chk("ill cancel", 64'(out_sfo_cancel), 64'd1);

        // backpressure then release with no bubble
        cyc(1, 32'h200, addi, addi, 2'b11, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'h300, addi, addi, 2'b11, 0, 0);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp pc held", 64'(out_pc), 64'h200);
        end
        cyc(1, 32'h300, addi, addi, 2'b11, 1, 0);
        chk("bp release valid", 64'(out_valid), 64'd1);
        chk("bp release pc", 64'(out_pc), 64'h300);

        // flush inside a shadow
        cyc(1, 32'h100, beq12, addi, 2'b11, 1, 0);
        cyc(1, 32'h104, addi, addi, 2'b11, 1, 1);
        chk("flush valid", 64'(out_valid), 64'd0);
        chk("flush active", 64'(shadow_active), 64'd0);
        cyc(1, 32'h104, addi, addi, 2'b11, 1, 0);
        chk("post flush shadowed", 64'(out_shadowed), 64'd0);

        // asynchronous reset mid-stream with a valid bundle held
        cyc(1, 32'h100, beq12, addi, 2'b11, 0, 0);
        #2 rst = 1;
        #1;
        chk("async rst valid", 64'(out_valid), 64'd0);
        chk("async rst active", 64'(shadow_active), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        mv = 0; mact = 0; mend = '0;
        @(negedge clk);
        rst = 0;

        // randomized traffic, mostly sequential fetch so shadows span bundles
        npc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0: pc = 32'($urandom) & 32'hFFFF_FFFC;
                1: pc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                default: pc = npc;
            endcase
            m = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            x = rnd_ins(); y = rnd_ins();
            if (!mv || out_ready || 1) ;
            cyc($urandom_range(0, 4) != 0, pc, x, y, m, $urandom_range(0, 9) < 7,
                $urandom_range(0, 29) == 0);
            if (mv && mpc == pc) npc = pc + 32'd8;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/decode_stage_nw.md
Name: decode_stage_nw

Overview:
- Parametrised N-wide registered decode stage between fetch and rename.
- Each lane decodes one RV32 instruction into a ctrl uop, a branch-ctrl record and a 20-bit packed immediate.
- A cross-bundle short-forward-branch (SFB) shadow tracker marks shadowed uops and cancels the shadow when a non-shadowable instruction appears.
- Output is a one-deep valid/ready pipeline register with backpressure and flush.

Parameters:
- WIDTH, 2, decode lanes per bundle (1..4).
- SHADOW_MAX_INSTRS, 4. A forward conditional branch opens a shadow only if its taken offset satisfies 0 < b_imm <= 4*SHADOW_MAX_INSTRS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  kill pipeline register and shadow state.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage can accept a bundle.
- in_pc  in  32  PC of lane 0; lane i PC = in_pc + 4*i.
- in_instr  in  WIDTH*32  lane i occupies bits [32i+31:32i].
- in_mask  in  WIDTH  per-lane instruction present.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  rename accepts the bundle.
- out_pc  out  32  registered in_pc.
- out_mask  out  WIDTH  registered in_mask.
- out_ctrl  out  WIDTH x ctrl struct  per-lane decode control (legal, uop, iq, exu, rd/rs usage, imm type).
- out_packed_imm  out  WIDTH*20  per-lane {imm[31:25], mid5, imm[19:12]}; mid5 = instr[11:7] for b/s types, else instr[24:20].
- out_illegal  out  WIDTH  lane valid and ctrl.legal = 0.
- out_shadowed  out  WIDTH  lane executes under an SFB shadow.
- out_sfo_cancel  out  1  this bundle cancelled an open shadow.
- shadow_active  out  1  tracker currently in SHADOW.

Behaviour:
- Reset: out_valid=0, all out_* registers 0, shadow state IDLE, shadow_end=0, in_ready=1.
- in_ready = !out_valid || out_ready; combinational, independent of in_valid.
- Accept = in_valid && in_ready && !flush.
- On accept, all outputs load on the next edge; latency is 1 cycle.
- out_valid clears on (out_valid && out_ready && !accept).
- Outputs hold stable while out_valid && !out_ready.
- flush: on the next edge out_valid=0 and state returns to IDLE; the flush-cycle input is dropped. flush overrides accept.
- Lanes with in_mask=0 have zero outputs and do not affect the tracker.
- Tracker states are IDLE and SHADOW(shadow_end[31:0]). Lanes are evaluated in order 0..WIDTH-1 using the running state.
- In SHADOW, lane pc >= shadow_end: leave to IDLE, then evaluate the lane as in IDLE. The instruction at shadow_end is not shadowed.
- In SHADOW, pc < shadow_end, instruction shadowable and legal: shadowed=1.
- In SHADOW, pc < shadow_end, instruction non-shadowable or illegal (branches, jumps, loads, stores): cancel.
  - Set out_sfo_cancel.
  - Clear out_shadowed on every lane of this bundle.
  - Go to IDLE, then evaluate the lane as in IDLE.
  - Downstream uses out_sfo_cancel to unshadow earlier bundles.
- In IDLE, a conditional branch with eligible offset moves to SHADOW with shadow_end = pc + b_imm (32-bit wrap). Not eligible: b_imm <= 0 or b_imm > 4*SHADOW_MAX_INSTRS.
- A branch never shadows itself.
- The state register updates only on accept. shadow_active reflects the registered state.
- An unshadowed bundle that ends inside the window carries the shadow into the next bundle.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, shadow_active=0, in_ready=1 immediately (async).
- Basic, WIDTH=2: in_pc=0x100, instrs {0x00108093, 0x00108093}, mask 11 -> next cycle out_valid=1, out_pc=0x100, both ctrl.legal=1, out_shadowed=00, out_illegal=00.
- Shadow across bundles:
  - Bundle 0x100 {0x00000663 beq +12, addi} -> shadowed=10 (lane1), shadow_active=1.
  - Bundle 0x108 {addi, addi} -> shadowed=01 (lane0 only); 0x10C is not shadowed; shadow_active=0.
  - beq +20 (0x00000A63) -> no shadow.
- Cancel: beq +12 at 0x100, then bundle 0x108 {0x00002023 sw, addi} -> out_sfo_cancel=1, shadowed=00, shadow_active=0.
  - Illegal 0xFFFFFFFF at 0x108 -> out_illegal=01, out_sfo_cancel=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Release -> held bundle leaves, new one loads the same edge, no bubble.
- Flush in shadow: after beq +12 at 0x100, assert flush with in_valid=1 -> next cycle out_valid=0, shadow_active=0. Following bundle 0x104 {addi, addi} -> shadowed=00.
